uart_cmd_decoder: RTL

- Frame decoder between the debug UART receiver (rx_data/rx_data_valid) and the audio effect chain (EQ, echo, reverb, interleaver).
- Assembles fixed 14-byte command frames: 2-byte header, 10-byte payload P0..P9, trailer 0x0D 0x0A.
- Validates and range-clamps each frame, then updates the registered control outputs in a single cycle.
- Inter-byte timeout and error reporting keep the link in sync after lost bytes.

---
 rtl/uart_cmd_decoder.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 14-byte UART command frames
// (2-byte header, 10-byte payload, 0x0D 0x0A trailer), validates and clamps
// them, and drives the registered control outputs of the audio effect chain.
module uart_cmd_decoder #(
    parameter int CLK_FRE    = 27,    // MHz
    parameter int TIMEOUT_US = 2000,  // inter-byte timeout
    parameter int ECHO_MAX   = 50     // max echo/reverb delay code
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic [79:0] all_gain,
    output logic        gain_change,
    output logic [7:0]  relay,
    output logic [1:0]  echo_gain,
    output logic [2:0]  drya,
    output logic [3:0]  factor,
    output logic        eq_switch,
    output logic        echo_switch,
    output logic        reverb_switch,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int          TMO_CYCLES = CLK_FRE * TIMEOUT_US;
    localparam int          TW         = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [7:0]  ECHO_MAX_B = 8'(ECHO_MAX);
    localparam logic [79:0] GAIN_RST   = {8'd4, 8'd4, 8'd4, 56'd0};

    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_PAYLOAD, S_TR0, S_TR1, S_APPLY} state_e;
    typedef enum logic [2:0] {K_NONE, K_EQ, K_ECHO, K_REVERB, K_FACTOR,
                              K_EQ_SW, K_ECHO_SW, K_REVERB_SW} kind_e;

    // A byte that can open a frame.
    function automatic logic is_h0(input logic [7:0] b);
        return b inside {8'hFE, 8'h0A, 8'h0C, 8'h0B, 8'h12, 8'h13, 8'h31};
    endfunction

    // Frame kind selected by a header pair; K_NONE if the pair is not a header.
    function automatic kind_e pair_kind(input logic [7:0] h0, input logic [7:0] h1);
        unique case ({h0, h1})
            16'hFEFE: return K_EQ;
            16'h0A0B: return K_ECHO;
            16'h0C0D: return K_REVERB;
            16'h0B0C: return K_FACTOR;
            16'h1231: return K_EQ_SW;
            16'h1342: return K_ECHO_SW;
            16'h3132: return K_REVERB_SW;
            default:  return K_NONE;
        endcase
    endfunction

    // Switch command: returns {accepted, new value}.
    function automatic logic [1:0] switch_next(input logic cur, input logic [7:0] p0);
        unique case (p0)
            8'h00:   return 2'b10;
            8'h01:   return 2'b11;
            8'hFF:   return {1'b1, ~cur};
            default: return {1'b0, cur};
        endcase
    endfunction

    state_e        state_q, state_d;
    kind_e         kind_q, kind_d, hdr_kind;
    logic [7:0]    h0_q, h0_d;
    logic [79:0]   payload_q, payload_d;  // P0 lands in [79:72] after 10 shifts
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [79:0]   all_gain_q, all_gain_d;
    logic [7:0]    relay_q, relay_d;
    logic [1:0]    echo_gain_q, echo_gain_d;
    logic [2:0]    drya_q, drya_d;
    logic [3:0]    factor_q, factor_d;
    logic          eq_sw_q, eq_sw_d, echo_sw_q, echo_sw_d, rev_sw_q, rev_sw_d;
    logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic          gain_change_q, gain_change_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [1:0]    sw;
    logic          busy, timeout;

    logic [7:0] p0, p8, p9;
    assign p0 = payload_q[79:72];
    assign p8 = payload_q[15:8];
    assign p9 = payload_q[7:0];

    // The inter-byte timer only runs while a frame is partially received.
    assign busy    = state_q inside {S_HDR1, S_PAYLOAD, S_TR0, S_TR1};
    assign timeout = busy && !rx_data_valid && (tmr_q == TMO_LAST);

    // Next-state, frame assembly and apply logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        kind_d        = kind_q;
        h0_d          = h0_q;
        payload_d     = payload_q;
        cnt_d         = cnt_q;
        all_gain_d    = all_gain_q;
        relay_d       = relay_q;
        echo_gain_d   = echo_gain_q;
        drya_d        = drya_q;
        factor_d      = factor_q;
        eq_sw_d       = eq_sw_q;
        echo_sw_d     = echo_sw_q;
        rev_sw_d      = rev_sw_q;
        frame_ok_d    = 1'b0;
        frame_err_d   = 1'b0;
        gain_change_d = 1'b0;
        hdr_kind      = K_NONE;
        sw            = 2'b00;
        tmr_d         = (busy && !rx_data_valid && !timeout) ? tmr_q + TW'(1) : '0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_data_valid && is_h0(rx_data)) begin
                    h0_d    = rx_data;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (rx_data_valid) begin
                    hdr_kind = pair_kind(h0_q, rx_data);
                    if (hdr_kind != K_NONE) begin
                        kind_d  = hdr_kind;
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end else if (is_h0(rx_data)) begin
                        h0_d = rx_data;  // stray byte may itself start a frame
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (rx_data_valid) begin
                    payload_d = {payload_q[71:0], rx_data};
                    if (cnt_q == 4'd9) begin
                        cnt_d   = '0;
                        state_d = S_TR0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            S_TR0, S_TR1: begin
                if (rx_data_valid) begin
                    if (state_q == S_TR0 && rx_data == 8'h0D) begin
                        state_d = S_TR1;
                    end else if (state_q == S_TR1 && rx_data == 8'h0A) begin
                        state_d = S_APPLY;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            S_APPLY: begin
                frame_ok_d = 1'b1;
                unique case (kind_q)
                    K_EQ: begin
                        all_gain_d    = payload_q;
                        gain_change_d = 1'b1;
                    end
                    K_ECHO: begin
                        relay_d     = (p9 > ECHO_MAX_B) ? ECHO_MAX_B : p9;
                        echo_gain_d = (p8 > 8'd3) ? 2'd3 : p8[1:0];
                    end
                    K_REVERB: begin
                        relay_d = (p9 > ECHO_MAX_B) ? ECHO_MAX_B : p9;
                        drya_d  = (p8 > 8'd7) ? 3'd7 : p8[2:0];
                    end
                    K_FACTOR: begin
                        if (p9 == 8'd0 || p9 > 8'd15) frame_ok_d = 1'b0;
                        else                           factor_d   = p9[3:0];
                    end
                    K_EQ_SW: begin
                        sw = switch_next(eq_sw_q, p0);
                        eq_sw_d    = sw[0];
                        frame_ok_d = sw[1];
                    end
                    K_ECHO_SW: begin
                        sw = switch_next(echo_sw_q, p0);
                        echo_sw_d  = sw[0];
                        frame_ok_d = sw[1];
                    end
                    K_REVERB_SW: begin
                        sw = switch_next(rev_sw_q, p0);
                        rev_sw_d   = sw[0];
                        frame_ok_d = sw[1];
                    end
                    default: frame_ok_d = 1'b0;
                endcase
                frame_err_d = !frame_ok_d;
                // A byte arriving now is handled as if in IDLE so it is not lost.
                state_d = S_IDLE;
                if (rx_data_valid && is_h0(rx_data)) begin
                    h0_d    = rx_data;
                    state_d = S_HDR1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_cnt_d = (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // All state and registered outputs; async reset restores power-on values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            kind_q        <= K_NONE;
            h0_q          <= '0;
            payload_q     <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            all_gain_q    <= GAIN_RST;
            relay_q       <= 8'd40;
            echo_gain_q   <= 2'd2;
            drya_q        <= 3'd3;
            factor_q      <= 4'd1;
            eq_sw_q       <= 1'b0;
            echo_sw_q     <= 1'b0;
            rev_sw_q      <= 1'b0;
            frame_ok_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            gain_change_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            kind_q        <= kind_d;
            h0_q          <= h0_d;
            payload_q     <= payload_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            all_gain_q    <= all_gain_d;
            relay_q       <= relay_d;
            echo_gain_q   <= echo_gain_d;
            drya_q        <= drya_d;
            factor_q      <= factor_d;
            eq_sw_q       <= eq_sw_d;
            echo_sw_q     <= echo_sw_d;
            rev_sw_q      <= rev_sw_d;
            frame_ok_q    <= frame_ok_d;
            frame_err_q   <= frame_err_d;
            gain_change_q <= gain_change_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign all_gain      = all_gain_q;
    assign gain_change   = gain_change_q;
    assign relay         = relay_q;
    assign echo_gain     = echo_gain_q;
    assign drya          = drya_q;
    assign factor        = factor_q;
    assign eq_switch     = eq_sw_q;
    assign echo_switch   = echo_sw_q;
    assign reverb_switch = rev_sw_q;
    assign frame_ok      = frame_ok_q;
    assign frame_err     = frame_err_q;
    assign err_cnt       = err_cnt_q;

endmodule
